// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM/WB pipeline stage: FSM encoding, widths,
// the error pattern returned on aborted loads and the write-back enable rule.
package pipe_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;

    localparam logic [REG_W-1:0]  REG_ZERO     = 5'd0;
    localparam logic [WORD_W-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    // Register 0 is hard-wired, so a write to it is never a real write-back.
    function automatic logic wb_en(input logic regwr, input logic [REG_W-1:0] rw);
        return regwr & (rw != REG_ZERO);
    endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Watchdog counter for outstanding data-memory accesses: clear, increment and
// terminal-count flag. State advances on the falling clock edge like the pipeline.
module dmem_timeout_cnt #(
    parameter int               CNT_W = 4,
    parameter logic [CNT_W-1:0] TERM  = {CNT_W{1'b1}}
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, saturate at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc_i && (cnt_q != TERM)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TERM);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with data-memory req/ack handshake and the MEM/WB register.
// Define MEM_FWD_EN to add a registered WB->EXE forwarding copy (fwd_* outputs).
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int                ADDR_W      = 10,
    parameter int                TIMEOUT_CYC = 15,
    parameter logic [WORD_W-1:0] ERR_DATA    = ERR_DATA_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              MEM_RegWr,
    input  logic              MEM_MemWr,
    input  logic              MEM_MemtoReg,
    input  logic [REG_W-1:0]  MEM_Rw,
    input  logic [WORD_W-1:0] MEM_Result,
    input  logic [WORD_W-1:0] MEM_busB,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [WORD_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              err,
    output logic              WB_RegWr,
    output logic [REG_W-1:0]  WB_Rw,
    output logic [WORD_W-1:0] WB_Data
`ifdef MEM_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rw,
    output logic [WORD_W-1:0] fwd_data
`endif
);

    mem_state_e state_q;
    logic       mem_op_s;
    logic       misalign_s;
    logic       cnt_clr_s;
    logic       cnt_tc_s;
    logic       done_s;

    assign mem_op_s   = MEM_MemWr | MEM_MemtoReg;
    assign misalign_s = (MEM_Result[1:0] != 2'b00);
    assign stall      = (state_q == ST_ACCESS) | ((state_q == ST_IDLE) & run & mem_op_s);
    assign done_s     = (state_q == ST_ACCESS) & (dmem_ack | cnt_tc_s);
    assign cnt_clr_s  = (state_q != ST_ACCESS) | dmem_ack | cnt_tc_s;

    dmem_timeout_cnt #(
        .CNT_W (CNT_W),
        .TERM  (CNT_W'(TIMEOUT_CYC))
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr_s),
        .inc_i (state_q == ST_ACCESS),
        .tc_o  (cnt_tc_s)
    );

    // Access FSM, memory request registers, sticky error and MEM/WB register.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= {ADDR_W{1'b0}};
            dmem_wdata <= {WORD_W{1'b0}};
            err        <= 1'b0;
            WB_RegWr   <= 1'b0;
            WB_Rw      <= REG_ZERO;
            WB_Data    <= {WORD_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run && !mem_op_s) begin
                        WB_RegWr <= wb_en(MEM_RegWr, MEM_Rw);
                        WB_Rw    <= MEM_Rw;
                        WB_Data  <= MEM_Result;
                    end else if (run && misalign_s) begin
                        // Misaligned: never reaches memory; loads get the error pattern.
                        err   <= 1'b1;
                        WB_Rw <= MEM_Rw;
                        if (MEM_MemWr) begin
                            WB_RegWr <= 1'b0;
                        end else begin
                            WB_RegWr <= wb_en(MEM_RegWr, MEM_Rw);
                            WB_Data  <= ERR_DATA;
                        end
                    end else if (run) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MEM_MemWr;
                        dmem_addr  <= MEM_Result[ADDR_W+1:2];
                        dmem_wdata <= MEM_busB;
                        WB_RegWr   <= 1'b0;
                        state_q    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    WB_RegWr <= 1'b0;
                    if (done_s) begin
                        dmem_req <= 1'b0;
                        state_q  <= ST_IDLE;
                        WB_Rw    <= MEM_Rw;
                        if (!dmem_ack) begin
                            err <= 1'b1;
                        end
                        // dmem_we still tells whether the held access is a store.
                        if (dmem_we) begin
                            WB_RegWr <= wb_en(MEM_RegWr & ~MEM_MemtoReg, MEM_Rw);
                            WB_Data  <= MEM_Result;
                        end else begin
                            WB_RegWr <= wb_en(MEM_RegWr, MEM_Rw);
                            WB_Data  <= dmem_ack ? dmem_rdata : ERR_DATA;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    dmem_req <= 1'b0;
                    WB_RegWr <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_FWD_EN
    // One-cycle delayed copy of the write-back bundle for the WB->EXE bypass.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid <= 1'b0;
            fwd_rw    <= REG_ZERO;
            fwd_data  <= {WORD_W{1'b0}};
        end else begin
            fwd_valid <= WB_RegWr;
            fwd_rw    <= WB_Rw;
            fwd_data  <= WB_Data;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed ops push expected memory requests
// and write-back results; monitors pop and compare when the DUT presents them.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        MEM_RegWr, MEM_MemWr, MEM_MemtoReg;
    logic [4:0]  MEM_Rw;
    logic [31:0] MEM_Result, MEM_busB;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        stall, err, WB_RegWr;
    logic [4:0]  WB_Rw;
    logic [31:0] WB_Data;
`ifdef MEM_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rw;
    logic [31:0] fwd_data;
`endif

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .MEM_RegWr(MEM_RegWr), .MEM_MemWr(MEM_MemWr), .MEM_MemtoReg(MEM_MemtoReg),
        .MEM_Rw(MEM_Rw), .MEM_Result(MEM_Result), .MEM_busB(MEM_busB),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .err(err),
        .WB_RegWr(WB_RegWr), .WB_Rw(WB_Rw), .WB_Data(WB_Data)
`ifdef MEM_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_rw(fwd_rw), .fwd_data(fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        regwr;
        logic [4:0]  rw;
        logic [31:0] data;
        logic        chk_data;
        logic        err;
        string       name;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];
    event     wb_ev;
    int       n_tests = 0;
    int       n_fail  = 0;
    int       ack_delay = 0;
    logic [31:0] rd_val = 32'h0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Data memory model: ack (with read data) after ack_delay cycles of req; 0 = never.
    initial begin
        int wait_n;
        wait_n = 0;
        forever begin
            @(posedge clk);
            if (dmem_req === 1'b1 && dmem_ack !== 1'b1) begin
                wait_n = wait_n + 1;
                if (ack_delay != 0 && wait_n == ack_delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rd_val;
                end
            end else begin
                dmem_ack = 1'b0;
                wait_n   = 0;
            end
        end
    end

    // Request monitor: compares each new request against the expected queue.
    initial begin
        logic prev_req;
        req_exp_t e;
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            if (dmem_req === 1'b1 && prev_req !== 1'b1) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", 32'd1, 32'd0);
                end else begin
                    e = req_q.pop_front();
                    chk("req_we",    {31'd0, dmem_we}, {31'd0, e.we});
                    chk("req_addr",  {22'd0, dmem_addr}, {22'd0, e.addr});
                    chk("req_wdata", dmem_wdata, e.wdata);
                end
            end
            prev_req = dmem_req;
        end
    end

    // Write-back monitor: compares the MEM/WB register each time an op retires.
    initial begin
        wb_exp_t e;
        forever begin
            @(wb_ev);
            #1;
            if (wb_q.size() == 0) begin
                chk("wb_queue_empty", 32'd1, 32'd0);
            end else begin
                e = wb_q.pop_front();
                chk({e.name, "_regwr"}, {31'd0, WB_RegWr}, {31'd0, e.regwr});
                chk({e.name, "_rw"},    {27'd0, WB_Rw},    {27'd0, e.rw});
                if (e.chk_data) chk({e.name, "_data"}, WB_Data, e.data);
                chk({e.name, "_err"},   {31'd0, err},      {31'd0, e.err});
            end
        end
    end

    task automatic push_wb(input logic regwr, input logic [4:0] rw, input logic [31:0] data,
                           input logic chk_data, input logic e_err, input string nm);
        wb_exp_t e;
        e.regwr = regwr; e.rw = rw; e.data = data; e.chk_data = chk_data;
        e.err = e_err; e.name = nm;
        wb_q.push_back(e);
    endtask

    task automatic push_req(input logic we, input logic [9:0] addr, input logic [31:0] wdata);
        req_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata;
        req_q.push_back(e);
    endtask

    task automatic idle_bundle();
        run = 1'b0; MEM_RegWr = 1'b0; MEM_MemWr = 1'b0; MEM_MemtoReg = 1'b0;
        MEM_Rw = 5'd0; MEM_Result = 32'h0; MEM_busB = 32'h0;
    endtask

    // Issue one op, hold it while the access is outstanding, then retire it.
    task automatic do_op(input logic regwr, input logic memwr, input logic memtoreg,
                         input logic [4:0] rw, input logic [31:0] res, input logic [31:0] busb,
                         input int exp_access, input string nm);
        int n;
        @(posedge clk);
        run = 1'b1; MEM_RegWr = regwr; MEM_MemWr = memwr; MEM_MemtoReg = memtoreg;
        MEM_Rw = rw; MEM_Result = res; MEM_busB = busb;
        #1;
        chk({nm, "_stall_issue"}, {31'd0, stall}, {31'd0, memwr | memtoreg});
        @(posedge clk);
        n = 0;
        while (dmem_req === 1'b1 && n < 64) begin
            n++;
            chk({nm, "_stall_access"}, {31'd0, stall}, 32'd1);
            @(posedge clk);
        end
        chk({nm, "_access_cycles"}, n, exp_access);
        idle_bundle();
        -> wb_ev;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        idle_bundle();
        #17 rst_n = 1'b1;
        #1;
        chk("rst_req",   {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall},    32'd0);
        chk("rst_err",   {31'd0, err},      32'd0);
        chk("rst_wb_regwr", {31'd0, WB_RegWr}, 32'd0);
        chk("rst_wb_rw",    {27'd0, WB_Rw},    32'd0);
        chk("rst_wb_data",  WB_Data,           32'd0);

        push_wb(1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b0, "alu");
        do_op(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'h0, 0, "alu");

        push_wb(1'b0, 5'd0, 32'h0000_0055, 1'b1, 1'b0, "alu_r0");
        do_op(1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0055, 32'h0, 0, "alu_r0");

        // Frozen pipeline: a pending load must neither stall nor reach memory.
        push_wb(1'b0, 5'd0, 32'h0000_0055, 1'b1, 1'b0, "run0_hold");
        @(posedge clk);
        MEM_RegWr = 1'b1; MEM_MemtoReg = 1'b1; MEM_Rw = 5'd9; MEM_Result = 32'h0000_0998;
        #1 chk("run0_stall", {31'd0, stall}, 32'd0);
        repeat (3) @(posedge clk);
        chk("run0_req", {31'd0, dmem_req}, 32'd0);
        idle_bundle();
        -> wb_ev;

        ack_delay = 3; rd_val = 32'hCAFE_F00D;
        push_req(1'b0, 10'h010, 32'h0000_0000);
        push_wb(1'b1, 5'd3, 32'hCAFE_F00D, 1'b1, 1'b0, "load");
        do_op(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0040, 32'h0, 3, "load");

        ack_delay = 2;
        push_req(1'b1, 10'h002, 32'h0000_00AA);
        push_wb(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "store");
        do_op(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0008, 32'h0000_00AA, 2, "store");

        ack_delay = 1;
        push_req(1'b1, 10'h003, 32'h0000_0077);
        push_wb(1'b0, 5'd4, 32'h0, 1'b0, 1'b0, "st_ld");
        do_op(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_000C, 32'h0000_0077, 1, "st_ld");

        push_wb(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b1, "misalign");
        do_op(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0041, 32'h0, 0, "misalign");

        // No ack: the 16th access edge sees the counter at 15 and aborts.
        ack_delay = 0;
        push_req(1'b0, 10'h020, 32'h0000_0000);
        push_wb(1'b1, 5'd8, 32'hDEAD_BEEF, 1'b1, 1'b1, "timeout");
        do_op(1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0080, 32'h0, 16, "timeout");

        // Reset while a load is outstanding.
        push_req(1'b0, 10'h040, 32'h0000_0000);
        @(posedge clk);
        run = 1'b1; MEM_RegWr = 1'b1; MEM_MemtoReg = 1'b1; MEM_Rw = 5'd2;
        MEM_Result = 32'h0000_0100;
        repeat (3) @(posedge clk);
        idle_bundle();
        #1 chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_req",   {31'd0, dmem_req}, 32'd0);
        chk("midrst_stall", {31'd0, stall},    32'd0);
        chk("midrst_err",   {31'd0, err},      32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        push_wb(1'b1, 5'd10, 32'h0000_0ABC, 1'b1, 1'b0, "post_rst");
        do_op(1'b1, 1'b0, 1'b0, 5'd10, 32'h0000_0ABC, 32'h0, 0, "post_rst");

        ack_delay = 1; rd_val = 32'h1357_9BDF;
        push_req(1'b0, 10'h001, 32'h0000_0000);
        push_wb(1'b1, 5'd11, 32'h1357_9BDF, 1'b1, 1'b0, "post_rst_load");
        do_op(1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_0004, 32'h0, 1, "post_rst_load");

        repeat (3) @(posedge clk);
        chk("wb_q_drained",  wb_q.size(),  32'd0);
        chk("req_q_drained", req_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
